// File: rtl/soc_pio_pkg.sv
// -----------------------------------------------------------------------------
// soc_pio_pkg
// Shared definitions for the SoC parallel-I/O input peripherals: register
// word addresses, edge-capture mode encodings and the system bus data width.
// No ports (package).
// -----------------------------------------------------------------------------
package soc_pio_pkg;

  // System interconnect data-bus width.
  localparam int PIO_BUS_W = 32;

  // Register word address type and register map.
  typedef logic [1:0] pio_addr_t;

  localparam pio_addr_t PIO_ADDR_DATA    = 2'd0;
  localparam pio_addr_t PIO_ADDR_IRQMASK = 2'd1;
  localparam pio_addr_t PIO_ADDR_RSVD    = 2'd2;
  localparam pio_addr_t PIO_ADDR_EDGE    = 2'd3;

  // Edge-capture mode encodings for the EDGE_TYPE parameter.
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;

endpackage : soc_pio_pkg

// File: rtl/soc_pio_in_capture_if.sv
// -----------------------------------------------------------------------------
// soc_pio_in_capture_if
// Avalon-MM slave register bus for the PIO input-capture peripheral.
// Signals:
//   address   [1:0]  word address of register
//   read             read strobe
//   write            write strobe
//   writedata [31:0] write data
//   readdata  [31:0] registered read data (1-clock latency, no waitrequest)
// Modports: master (interconnect side), slave (peripheral side).
// -----------------------------------------------------------------------------
interface soc_pio_in_capture_if;
  import soc_pio_pkg::*;

  pio_addr_t              address;
  logic                   read;
  logic                   write;
  logic [PIO_BUS_W-1:0]   writedata;
  logic [PIO_BUS_W-1:0]   readdata;

  modport master (
    output address,
    output read,
    output write,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  read,
    input  write,
    input  writedata,
    output readdata
  );

endinterface : soc_pio_in_capture_if

// File: rtl/soc_sync_chain.sv
// -----------------------------------------------------------------------------
// soc_sync_chain
// Parametrised WIDTH x SYNC_STAGES flip-flop synchroniser for asynchronous
// inputs. Every bit passes through SYNC_STAGES flops; dout is the last stage.
// Ports:
//   clk   in   system clock
//   rst   in   asynchronous active-high reset (all stages clear to 0)
//   din   in   [WIDTH-1:0] asynchronous inputs
//   dout  out  [WIDTH-1:0] synchronised outputs
// -----------------------------------------------------------------------------
module soc_sync_chain #(
  parameter int WIDTH       = 1,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage_r [SYNC_STAGES];

  // Shift register: stage 0 samples the raw input, later stages resolve metastability.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        stage_r[i] <= '0;
      end
    end else begin
      stage_r[0] <= din;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  assign dout = stage_r[SYNC_STAGES-1];

endmodule : soc_sync_chain

// File: rtl/soc_pio_in_capture.sv
// -----------------------------------------------------------------------------
// soc_pio_in_capture
// General-purpose input peripheral: synchronises in_port, detects edges into a
// sticky EDGECAPTURE register and raises a maskable level interrupt.
// Register map (32-bit, zero-extended from WIDTH):
//   0 DATA        read-only, synchronised input value
//   1 IRQMASK     read/write
//   2 reserved    reads 0, writes ignored
//   3 EDGECAPTURE read sticky bits; write clears
// Configuration macro SOC_PIO_BITCLR_EN:
//   defined   - EDGECAPTURE write clears only bits where writedata=1
//   undefined - any EDGECAPTURE write clears all bits
//   A newly detected edge always wins over a simultaneous clear.
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-high reset
//   avs      slave modport of soc_pio_in_capture_if (register bus)
//   in_port  in   [WIDTH-1:0] asynchronous external inputs
//   irq      out  level interrupt, |(edgecapture & irqmask)
// -----------------------------------------------------------------------------
module soc_pio_in_capture
  import soc_pio_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter int               SYNC_STAGES = 2,
  parameter int               EDGE_TYPE   = 0,
  parameter logic [WIDTH-1:0] RESET_MASK  = '0
) (
  input  logic                  clk,
  input  logic                  reset,
  soc_pio_in_capture_if.slave   avs,
  input  logic [WIDTH-1:0]      in_port,
  output logic                  irq
);

  logic [WIDTH-1:0]     data_s;
  logic [WIDTH-1:0]     prev_r;
  logic [WIDTH-1:0]     edge_r;
  logic [WIDTH-1:0]     mask_r;
  logic [WIDTH-1:0]     rise_s;
  logic [WIDTH-1:0]     fall_s;
  logic [WIDTH-1:0]     event_s;
  logic [WIDTH-1:0]     clr_s;
  logic [WIDTH-1:0]     edge_nxt_s;
  logic                 wr_edge_s;
  logic                 wr_mask_s;
  logic [PIO_BUS_W-1:0] rd_mux_s;
  logic [PIO_BUS_W-1:0] readdata_r;

  soc_sync_chain #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk  (clk),
    .rst  (reset),
    .din  (in_port),
    .dout (data_s)
  );

  assign rise_s    = data_s & ~prev_r;
  assign fall_s    = ~data_s & prev_r;
  assign wr_edge_s = avs.write && (avs.address == PIO_ADDR_EDGE);
  assign wr_mask_s = avs.write && (avs.address == PIO_ADDR_IRQMASK);

  // Select which transitions are captured according to EDGE_TYPE.
  always_comb begin
    event_s = rise_s;
    case (EDGE_TYPE)
      EDGE_RISE: event_s = rise_s;
      EDGE_FALL: event_s = fall_s;
      EDGE_ANY:  event_s = rise_s | fall_s;
      default:   event_s = rise_s;
    endcase
  end

  // Bits to clear in EDGECAPTURE on a write to its address.
  always_comb begin
    clr_s = '0;
    if (wr_edge_s) begin
`ifdef SOC_PIO_BITCLR_EN
      clr_s = avs.writedata[WIDTH-1:0];
`else
      clr_s = '1;
`endif
    end else begin
      clr_s = '0;
    end
  end

  // Clear is applied first so a same-cycle new edge keeps its bit set.
  assign edge_nxt_s = (edge_r & ~clr_s) | event_s;

  // Read mux, zero-extended to the bus width and forced to 0 when not reading.
  always_comb begin
    rd_mux_s = '0;
    if (avs.read) begin
      case (avs.address)
        PIO_ADDR_DATA:    rd_mux_s[WIDTH-1:0] = data_s;
        PIO_ADDR_IRQMASK: rd_mux_s[WIDTH-1:0] = mask_r;
        PIO_ADDR_EDGE:    rd_mux_s[WIDTH-1:0] = edge_r;
        default:          rd_mux_s = '0;
      endcase
    end else begin
      rd_mux_s = '0;
    end
  end

  // Previous-sample register for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prev_r <= '0;
    end else begin
      prev_r <= data_s;
    end
  end

  // Sticky edge-capture register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      edge_r <= '0;
    end else begin
      edge_r <= edge_nxt_s;
    end
  end

  // Interrupt mask register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_r <= RESET_MASK;
    end else if (wr_mask_s) begin
      mask_r <= avs.writedata[WIDTH-1:0];
    end
  end

  // Registered read data; captures pre-write register values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      readdata_r <= '0;
    end else begin
      readdata_r <= rd_mux_s;
    end
  end

  assign avs.readdata = readdata_r;
  assign irq          = |(edge_r & mask_r);

endmodule : soc_pio_in_capture

// File: tb/tb_soc_pio_in_capture.sv
// -----------------------------------------------------------------------------
// tb_soc_pio_in_capture
// Two instances share one stimulus stream:
//   dut_a: WIDTH=8, SYNC_STAGES=2, EDGE_TYPE=any,    RESET_MASK=0x00
//   dut_b: WIDTH=5, SYNC_STAGES=3, EDGE_TYPE=rising, RESET_MASK=0x16
// A cycle-level reference model built from the register-map rules predicts
// readdata and irq for both after every clock.
// -----------------------------------------------------------------------------
module tb_soc_pio_in_capture;

`ifdef SOC_PIO_BITCLR_EN
  localparam bit BITCLR = 1'b1;
`else
  localparam bit BITCLR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  pin;
  logic        irq_a;
  logic        irq_b;
  logic [1:0]  b_addr;
  logic        b_rd;
  logic        b_wr;
  logic [31:0] b_wd;

  int n_tests = 0;
  int n_fail  = 0;

  // Instance configuration: WIDTH, SYNC_STAGES, EDGE_TYPE, RESET_MASK.
  int          cfg_w  [2] = '{8, 5};
  int          cfg_ss [2] = '{2, 3};
  int          cfg_et [2] = '{2, 0};
  logic [31:0] cfg_rm [2] = '{32'h00, 32'h16};

  // Reference model state.
  logic [31:0] m_data [2];
  logic [31:0] m_prev [2];
  logic [31:0] m_ec   [2];
  logic [31:0] m_mask [2];
  logic [31:0] m_rd   [2];
  logic [7:0]  hist [$];

  always #5 clk = ~clk;

  soc_pio_in_capture_if bus_a ();
  soc_pio_in_capture_if bus_b ();

  assign bus_a.address   = b_addr;
  assign bus_a.read      = b_rd;
  assign bus_a.write     = b_wr;
  assign bus_a.writedata = b_wd;
  assign bus_b.address   = b_addr;
  assign bus_b.read      = b_rd;
  assign bus_b.write     = b_wr;
  assign bus_b.writedata = b_wd;

  soc_pio_in_capture #(
    .WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .RESET_MASK(8'h00)
  ) dut_a (
    .clk(clk), .reset(reset), .avs(bus_a.slave), .in_port(pin), .irq(irq_a)
  );

  soc_pio_in_capture #(
    .WIDTH(5), .SYNC_STAGES(3), .EDGE_TYPE(0), .RESET_MASK(5'h16)
  ) dut_b (
    .clk(clk), .reset(reset), .avs(bus_b.slave), .in_port(pin[4:0]), .irq(irq_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_irq(input int i);
    return {31'd0, |(m_ec[i] & m_mask[i])};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_data[i] = 32'd0;
      m_prev[i] = 32'd0;
      m_ec[i]   = 32'd0;
      m_mask[i] = cfg_rm[i];
      m_rd[i]   = 32'd0;
    end
    hist.delete();
  endtask

  // Advance the model by one clock using the inputs present before the edge.
  task automatic model_edge();
    hist.push_back(pin);
    if (hist.size() > 8) void'(hist.pop_front());
    for (int i = 0; i < 2; i++) begin
      logic [31:0] wm;
      logic [31:0] ev;
      logic [31:0] ec;
      wm = (32'd1 << cfg_w[i]) - 32'd1;
      // Read returns the register contents as they were before this edge.
      if (!b_rd)                m_rd[i] = 32'd0;
      else if (b_addr == 2'd0)  m_rd[i] = m_data[i];
      else if (b_addr == 2'd1)  m_rd[i] = m_mask[i];
      else if (b_addr == 2'd3)  m_rd[i] = m_ec[i];
      else                      m_rd[i] = 32'd0;
      // Transitions between the previous and current synchronised samples.
      if (cfg_et[i] == 0)       ev = m_data[i] & ~m_prev[i];
      else if (cfg_et[i] == 1)  ev = ~m_data[i] & m_prev[i];
      else                      ev = m_data[i] ^ m_prev[i];
      ec = m_ec[i];
      if (b_wr && b_addr == 2'd3) ec = BITCLR ? (ec & ~b_wd) : 32'd0;
      m_ec[i] = (ec | ev) & wm;
      if (b_wr && b_addr == 2'd1) m_mask[i] = b_wd & wm;
      m_prev[i] = m_data[i];
      // Synchronised value is the input seen SYNC_STAGES edges ago.
      if (hist.size() >= cfg_ss[i]) m_data[i] = {24'd0, hist[hist.size() - cfg_ss[i]]} & wm;
      else                          m_data[i] = 32'd0;
    end
  endtask

  task automatic drive(input logic [1:0] a, input logic r, input logic w, input logic [31:0] d);
    b_addr = a;
    b_rd   = r;
    b_wr   = w;
    b_wd   = d;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("rd_a",  bus_a.readdata, m_rd[0]);
    check("rd_b",  bus_b.readdata, m_rd[1]);
    check("irq_a", {31'd0, irq_a}, m_irq(0));
    check("irq_b", {31'd0, irq_b}, m_irq(1));
  endtask

  // Pulse reset between clock edges and check outputs clear without a clock.
  task automatic async_reset_pulse();
    #2 reset = 1'b1;
    #1;
    model_reset();
    check("rst_rd_a",  bus_a.readdata, 32'd0);
    check("rst_rd_b",  bus_b.readdata, 32'd0);
    check("rst_irq_a", {31'd0, irq_a}, 32'd0);
    check("rst_irq_b", {31'd0, irq_b}, 32'd0);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    pin   = 8'h00;
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    #1;
    model_reset();
    check("init_rd_a",  bus_a.readdata, 32'd0);
    check("init_irq_a", {31'd0, irq_a}, 32'd0);
    #2 reset = 1'b0;
    step();

    // DATA register readback after synchroniser latency; reserved reads 0.
    pin = 8'hA5;
    repeat (4) step();
    drive(2'd0, 1'b1, 1'b0, 32'd0);
    step();
    check("data_a", bus_a.readdata, 32'h0000_00A5);
    check("data_b", bus_b.readdata, 32'h0000_0005);
    drive(2'd2, 1'b1, 1'b1, 32'hFFFF_FFFF);
    step();
    check("rsvd_a", bus_a.readdata, 32'd0);

    // IRQMASK truncation to WIDTH.
    drive(2'd1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(2'd1, 1'b1, 1'b0, 32'd0);
    step();
    check("mask_a", bus_a.readdata, 32'h0000_00FF);
    check("mask_b", bus_b.readdata, 32'h0000_001F);

    // Quiesce: clear captures, mask bit0 only, inputs low and settled.
    drive(2'd3, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(2'd1, 1'b0, 1'b1, 32'h1);
    step();
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    pin = 8'h00;
    repeat (5) step();
    drive(2'd3, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    step();

    // Rising edge on bit0: dut_b captures after SYNC_STAGES+1 = 4 clocks.
    pin = 8'h01;
    repeat (3) step();
    check("irq_b_early", {31'd0, irq_b}, 32'd0);
    step();
    check("irq_b_set", {31'd0, irq_b}, 32'd1);
    drive(2'd3, 1'b1, 1'b0, 32'd0);
    step();
    check("ec_b_rise", bus_b.readdata, 32'h1);
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    pin = 8'h00;
    repeat (5) step();
    drive(2'd3, 1'b1, 1'b0, 32'd0);
    step();
    check("ec_b_fall_ignored", bus_b.readdata, 32'h1);

    // Clear of bit0 coincides with a new edge on bit0 in dut_a: set wins.
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    pin = 8'h01;
    repeat (2) step();
    drive(2'd3, 1'b0, 1'b1, 32'h1);
    step();
    check("setwins_irq_a", {31'd0, irq_a}, 32'd1);
    drive(2'd3, 1'b1, 1'b0, 32'd0);
    step();
    check("setwins_ec_a", bus_a.readdata & 32'h1, 32'h1);

    // Partial clear: pulse bits 0 and 3, then write 0x8 to EDGECAPTURE.
    drive(2'd3, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    pin = 8'h09;
    repeat (2) step();
    pin = 8'h00;
    repeat (5) step();
    drive(2'd3, 1'b0, 1'b1, 32'h8);
    step();
    drive(2'd3, 1'b1, 1'b0, 32'd0);
    step();
    check("bitclr_a", bus_a.readdata, BITCLR ? 32'h1 : 32'h0);

    // Read and write of IRQMASK together: readdata shows the old mask.
    drive(2'd1, 1'b1, 1'b1, 32'h3C);
    step();
    check("rw_old_a", bus_a.readdata, 32'h1);

    // Captures pending with irq high, then asynchronous reset.
    drive(2'd1, 1'b0, 1'b1, 32'hFFFF_FFFF);
    step();
    drive(2'd0, 1'b0, 1'b0, 32'd0);
    pin = 8'hFF;
    repeat (4) step();
    check("pre_rst_irq_a", {31'd0, irq_a}, 32'd1);
    async_reset_pulse();
    drive(2'd1, 1'b1, 1'b0, 32'd0);
    step();
    check("rst_mask_a", bus_a.readdata, 32'h00);
    check("rst_mask_b", bus_b.readdata, 32'h16);
    drive(2'd3, 1'b1, 1'b0, 32'd0);
    step();
    check("rst_ec_a", bus_a.readdata, 32'h0);

    // Randomised traffic against the model, with one mid-stream reset.
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 3) == 0) pin = 8'($urandom);
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 5) == 0), $urandom);
      step();
      if (k == 200) async_reset_pulse();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_soc_pio_in_capture
